// File: rtl/riscv_pkg.sv
// Shared RV64I pipeline definitions: memory opcodes, access sizes and EX5 FSM states.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_e;

  typedef enum logic {EX5_IDLE, EX5_ISSUE} ex5_state_e;

  function automatic mem_size_e f3_to_size(input logic [2:0] funct3);
    return mem_size_e'(funct3[1:0]);
  endfunction

endpackage

// File: rtl/riscv_ex5_stage_if.sv
// Data-memory request channel between EX5 (master) and the data memory (slave).
interface riscv_ex5_stage_if;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [63:0] dmem_req_addr;
  logic [63:0] dmem_req_wdata;
  logic [7:0]  dmem_req_wstrb;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    input  dmem_req_ready
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    output dmem_req_ready
  );
endinterface

// File: rtl/riscv_ex5_mem_align.sv
// Combinational store lane alignment: byte strobes, shifted store data and misalign flag.
module riscv_ex5_mem_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] rs2_data,
  input  logic        mem_op,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata,
  output logic        misalign
);

  mem_size_e   size;
  logic [2:0]  off;
  logic [3:0]  size_bytes;
  logic [2:0]  align_mask;
  logic [15:0] mask_wide;

  assign size       = f3_to_size(funct3);
  assign off        = addr[2:0];
  assign size_bytes = 4'd1 << size;
  assign align_mask = 3'(size_bytes - 4'd1);

  // Build the mask wide so a doubleword at a nonzero offset truncates at the word edge.
  assign mask_wide  = ((16'd1 << size_bytes) - 16'd1) << off;
  assign wstrb      = mask_wide[7:0];
  assign wdata      = rs2_data << {off, 3'b000};
  assign misalign   = mem_op & ((off & align_mask) != 3'd0);

endmodule

// File: rtl/riscv_ex5_stage.sv
// RV64I EX5 stage: memory-op decode, store alignment and data-memory request issue.
// Optional: define RISCV_EX5_MISALIGN_TRAP_EN to suppress issue of misaligned accesses.
module riscv_ex5_stage
  import riscv_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [63:0]            ex4_pc,
  input  logic [31:0]            ex4_inst,
  input  logic [63:0]            ex4_alu_result,
  input  logic [63:0]            ex4_rs2_data,
  input  logic [4:0]             ex4_rd_addr,
  input  logic [2:0]             ex4_funct3,
  input  logic                   ex4_valid,
  input  logic                   ex5_flush,
  riscv_ex5_stage_if.master      dmem,
  output logic [63:0]            ex5_pc,
  output logic [31:0]            ex5_inst,
  output logic [63:0]            ex5_alu_result,
  output logic [4:0]             ex5_rd_addr,
  output logic [2:0]             ex5_funct3,
  output logic                   ex5_is_load,
  output logic                   ex5_is_store,
  output logic                   ex5_valid,
  output logic                   ex5_misalign,
  output logic                   ex5_stall,
  output logic [STALL_CNT_W-1:0] ex5_stall_cycles
);

  logic        is_load_d;
  logic        is_store_d;
  logic        mem_op_d;
  logic [7:0]  wstrb_d;
  logic [63:0] wdata_d;
  logic        misalign_d;
  logic        issue_ok;
  logic        issuable;
  logic        capture;
  logic        req_valid;
  logic        req_we_q;
  logic [7:0]  req_wstrb_q;
  logic [63:0] req_wdata_q;
  ex5_state_e  state_q;
  ex5_state_e  state_d;

  assign is_load_d  = (ex4_inst[6:0] == OPC_LOAD);
  assign is_store_d = (ex4_inst[6:0] == OPC_STORE);
  assign mem_op_d   = is_load_d | is_store_d;

  riscv_ex5_mem_align u_align (
    .funct3   (ex4_funct3),
    .addr     (ex4_alu_result),
    .rs2_data (ex4_rs2_data),
    .mem_op   (mem_op_d),
    .wstrb    (wstrb_d),
    .wdata    (wdata_d),
    .misalign (misalign_d)
  );

`ifdef RISCV_EX5_MISALIGN_TRAP_EN
  assign issue_ok = ~misalign_d;
`else
  assign issue_ok = 1'b1;
`endif

  assign issuable  = ex4_valid & ~ex5_flush & mem_op_d & issue_ok;
  assign ex5_stall = req_valid & ~dmem.dmem_req_ready;
  assign capture   = ~ex5_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EX5_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    case (state_q)
      EX5_IDLE: begin
        if (capture && issuable) state_d = EX5_ISSUE;
      end
      EX5_ISSUE: begin
        req_valid = 1'b1;
        if (dmem.dmem_req_ready) state_d = issuable ? EX5_ISSUE : EX5_IDLE;
      end
      default: state_d = EX5_IDLE;
    endcase
  end

  // EX4 -> EX5 boundary: control state (reset) and payload (no reset), both frozen by stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex5_valid    <= 1'b0;
      ex5_is_load  <= 1'b0;
      ex5_is_store <= 1'b0;
      ex5_misalign <= 1'b0;
    end else if (capture) begin
      ex5_valid    <= ex4_valid & ~ex5_flush;
      ex5_is_load  <= is_load_d;
      ex5_is_store <= is_store_d;
      ex5_misalign <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      ex5_pc         <= ex4_pc;
      ex5_inst       <= ex4_inst;
      ex5_alu_result <= ex4_alu_result;
      ex5_rd_addr    <= ex4_rd_addr;
      ex5_funct3     <= ex4_funct3;
      req_we_q       <= is_store_d;
      req_wstrb_q    <= wstrb_d;
      req_wdata_q    <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             ex5_stall_cycles <= '0;
    else if (ex5_stall && !(&ex5_stall_cycles)) ex5_stall_cycles <= ex5_stall_cycles + 1'b1;
  end

  assign dmem.dmem_req_valid = req_valid;
  assign dmem.dmem_req_we    = req_we_q;
  assign dmem.dmem_req_addr  = ex5_alu_result;
  assign dmem.dmem_req_wdata = req_wdata_q;
  assign dmem.dmem_req_wstrb = req_wstrb_q;

endmodule

// File: tb/tb_riscv_ex5_stage.sv
// Scoreboard bench for riscv_ex5_stage: expected requests queued at drive time, checked at handshake.
module tb_riscv_ex5_stage;
  import riscv_pkg::*;

  localparam int STALL_CNT_W = 32;
  localparam logic [6:0] OPC_ALU = 7'b0010011;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [63:0]            ex4_pc, ex4_alu_result, ex4_rs2_data;
  logic [31:0]            ex4_inst;
  logic [4:0]             ex4_rd_addr;
  logic [2:0]             ex4_funct3;
  logic                   ex4_valid, ex5_flush;
  logic [63:0]            ex5_pc, ex5_alu_result;
  logic [31:0]            ex5_inst;
  logic [4:0]             ex5_rd_addr;
  logic [2:0]             ex5_funct3;
  logic                   ex5_is_load, ex5_is_store, ex5_valid, ex5_misalign, ex5_stall;
  logic [STALL_CNT_W-1:0] ex5_stall_cycles;

  riscv_ex5_stage_if dmem_if ();

  riscv_ex5_stage #(.STALL_CNT_W(STALL_CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex4_pc           (ex4_pc),
    .ex4_inst         (ex4_inst),
    .ex4_alu_result   (ex4_alu_result),
    .ex4_rs2_data     (ex4_rs2_data),
    .ex4_rd_addr      (ex4_rd_addr),
    .ex4_funct3       (ex4_funct3),
    .ex4_valid        (ex4_valid),
    .ex5_flush        (ex5_flush),
    .dmem             (dmem_if.master),
    .ex5_pc           (ex5_pc),
    .ex5_inst         (ex5_inst),
    .ex5_alu_result   (ex5_alu_result),
    .ex5_rd_addr      (ex5_rd_addr),
    .ex5_funct3       (ex5_funct3),
    .ex5_is_load      (ex5_is_load),
    .ex5_is_store     (ex5_is_store),
    .ex5_valid        (ex5_valid),
    .ex5_misalign     (ex5_misalign),
    .ex5_stall        (ex5_stall),
    .ex5_stall_cycles (ex5_stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_t;

  req_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Byte-lane reference: lane i of the word carries byte (i - off) of rs2 if inside the access.
  task automatic lane_model(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] rs2,
                            output logic [7:0] strb, output logic [63:0] data, output logic mis);
    int sz;
    int off;
    sz   = 1 << f3[1:0];
    off  = int'(addr[2:0]);
    strb = '0;
    data = '0;
    for (int i = 0; i < 8; i++) begin
      int lane;
      lane = i - off;
      if (lane >= 0 && lane < sz) begin
        strb[i]        = 1'b1;
        data[8*i +: 8] = rs2[8*lane +: 8];
      end
    end
    mis = (off % sz) != 0;
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] pc,
                       input logic [63:0] addr, input logic [63:0] rs2, input logic vld,
                       input logic flush);
    req_t       r;
    logic [7:0] s;
    logic [63:0] d;
    logic       m;
    ex4_pc         = pc;
    ex4_inst       = {7'h0, 5'd2, 5'd1, f3, 5'd3, opc};
    ex4_alu_result = addr;
    ex4_rs2_data   = rs2;
    ex4_rd_addr    = 5'd3;
    ex4_funct3     = f3;
    ex4_valid      = vld;
    ex5_flush      = flush;
    lane_model(f3, addr, rs2, s, d, m);
    if (vld && !flush && (opc == OPC_LOAD || opc == OPC_STORE)) begin
`ifdef RISCV_EX5_MISALIGN_TRAP_EN
      if (!m) begin
`else
      begin
`endif
        r.we = (opc == OPC_STORE);
        r.addr = addr;
        r.wdata = d;
        r.wstrb = s;
        sb.push_back(r);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && dmem_if.dmem_req_valid && dmem_if.dmem_req_ready) begin
      if (sb.size() == 0) chk("sb_req_without_expect", 64'(sb.size()), 64'd1);
      else begin
        req_t e;
        e = sb.pop_front();
        chk("sb_we",    64'(dmem_if.dmem_req_we),    64'(e.we));
        chk("sb_addr",  dmem_if.dmem_req_addr,       e.addr);
        chk("sb_wdata", dmem_if.dmem_req_wdata,      e.wdata);
        chk("sb_wstrb", 64'(dmem_if.dmem_req_wstrb), 64'(e.wstrb));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    dmem_if.dmem_req_ready = 1'b1;
    drive(OPC_ALU, 3'd0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 64'(dmem_if.dmem_req_valid), 64'd0);
    chk("rst_ex5_valid", 64'(ex5_valid), 64'd0);
    chk("rst_stall_cnt", 64'(ex5_stall_cycles), 64'd0);
    chk("rst_misalign",  64'(ex5_misalign), 64'd0);
    chk("rst_is_load",   64'(ex5_is_load), 64'd0);
    rst_n = 1'b1;
    step();

    // SD aligned, ready held high
    drive(OPC_STORE, 3'd3, 64'h100, 64'h1000, 64'h1122334455667788, 1'b1, 1'b0);
    step();
    chk("sd_req_valid", 64'(dmem_if.dmem_req_valid), 64'd1);
    chk("sd_we",        64'(dmem_if.dmem_req_we), 64'd1);
    chk("sd_wstrb",     64'(dmem_if.dmem_req_wstrb), 64'hFF);
    chk("sd_wdata",     dmem_if.dmem_req_wdata, 64'h1122334455667788);
    chk("sd_stall",     64'(ex5_stall), 64'd0);
    chk("sd_is_store",  64'(ex5_is_store), 64'd1);
    chk("sd_misalign",  64'(ex5_misalign), 64'd0);
    chk("sd_pc",        ex5_pc, 64'h100);
    chk("sd_alu",       ex5_alu_result, 64'h1000);
    chk("sd_rd",        64'(ex5_rd_addr), 64'd3);
    chk("sd_funct3",    64'(ex5_funct3), 64'd3);
    chk("sd_inst_opc",  64'(ex5_inst[6:0]), 64'(OPC_STORE));

    // SB then LW back-to-back
    drive(OPC_STORE, 3'd0, 64'h104, 64'h1003, 64'hAB, 1'b1, 1'b0);
    step();
    chk("sb_req_valid", 64'(dmem_if.dmem_req_valid), 64'd1);
    chk("sb_wstrb_c",   64'(dmem_if.dmem_req_wstrb), 64'h08);
    chk("sb_wdata_c",   dmem_if.dmem_req_wdata, 64'h00000000AB000000);
    drive(OPC_LOAD, 3'd2, 64'h108, 64'h2004, 64'hDEAD, 1'b1, 1'b0);
    step();
    chk("lw_req_valid", 64'(dmem_if.dmem_req_valid), 64'd1);
    chk("lw_wstrb",     64'(dmem_if.dmem_req_wstrb), 64'hF0);
    chk("lw_we",        64'(dmem_if.dmem_req_we), 64'd0);
    chk("lw_is_load",   64'(ex5_is_load), 64'd1);
    drive(OPC_ALU, 3'd0, 64'h10C, 64'h7, 64'h0, 1'b1, 1'b0);
    step();
    chk("alu_req_valid", 64'(dmem_if.dmem_req_valid), 64'd0);
    chk("alu_ex5_valid", 64'(ex5_valid), 64'd1);
    chk("alu_is_load",   64'(ex5_is_load), 64'd0);
    chk("alu_is_store",  64'(ex5_is_store), 64'd0);

    // Load under back-pressure for 3 cycles; next op held until ready
    dmem_if.dmem_req_ready = 1'b0;
    drive(OPC_LOAD, 3'd3, 64'h300, 64'h3008, 64'h0, 1'b1, 1'b0);
    step();
    chk("bp_stall_cnt0", 64'(ex5_stall_cycles), 64'd0);
    drive(OPC_ALU, 3'd0, 64'h304, 64'h1, 64'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_stall",     64'(ex5_stall), 64'd1);
      chk("bp_req_valid", 64'(dmem_if.dmem_req_valid), 64'd1);
      chk("bp_addr",      dmem_if.dmem_req_addr, 64'h3008);
      chk("bp_hold_pc",   ex5_pc, 64'h300);
      step();
    end
    chk("bp_stall_cnt3", 64'(ex5_stall_cycles), 64'd3);
    dmem_if.dmem_req_ready = 1'b1;
    #1;
    chk("bp_stall_rel", 64'(ex5_stall), 64'd0);
    step();
    chk("bp_next_pc",    ex5_pc, 64'h304);
    chk("bp_req_idle",   64'(dmem_if.dmem_req_valid), 64'd0);
    chk("bp_stall_hold", 64'(ex5_stall_cycles), 64'd3);

    // LH misaligned
    drive(OPC_LOAD, 3'd1, 64'h400, 64'h1001, 64'h1234, 1'b1, 1'b0);
    step();
    chk("lh_misalign", 64'(ex5_misalign), 64'd1);
`ifdef RISCV_EX5_MISALIGN_TRAP_EN
    chk("lh_req_valid", 64'(dmem_if.dmem_req_valid), 64'd0);
`else
    chk("lh_req_valid", 64'(dmem_if.dmem_req_valid), 64'd1);
    chk("lh_wstrb",     64'(dmem_if.dmem_req_wstrb), 64'h06);
`endif

    // Flush of incoming store, then flush while a request is pending
    drive(OPC_STORE, 3'd2, 64'h500, 64'h40, 64'h77, 1'b1, 1'b1);
    step();
    chk("fl_ex5_valid", 64'(ex5_valid), 64'd0);
    chk("fl_req_valid", 64'(dmem_if.dmem_req_valid), 64'd0);
    dmem_if.dmem_req_ready = 1'b0;
    drive(OPC_STORE, 3'd3, 64'h504, 64'h50, 64'h55, 1'b1, 1'b0);
    step();
    chk("flp_req_valid0", 64'(dmem_if.dmem_req_valid), 64'd1);
    drive(OPC_STORE, 3'd3, 64'h508, 64'h58, 64'h66, 1'b1, 1'b1);
    step();
    chk("flp_req_valid1", 64'(dmem_if.dmem_req_valid), 64'd1);
    chk("flp_addr",       dmem_if.dmem_req_addr, 64'h50);
    dmem_if.dmem_req_ready = 1'b1;
    step();
    chk("flp_req_done",  64'(dmem_if.dmem_req_valid), 64'd0);
    chk("flp_ex5_valid", 64'(ex5_valid), 64'd0);
    chk("flp_stall_cnt", 64'(ex5_stall_cycles), 64'd4);

    // Reset while a request is outstanding
    dmem_if.dmem_req_ready = 1'b0;
    drive(OPC_LOAD, 3'd3, 64'h600, 64'h6000, 64'h0, 1'b1, 1'b0);
    step();
    chk("rr_req_valid", 64'(dmem_if.dmem_req_valid), 64'd1);
    void'(sb.pop_back());
    drive(OPC_ALU, 3'd0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rr_req_drop",  64'(dmem_if.dmem_req_valid), 64'd0);
    chk("rr_ex5_valid", 64'(ex5_valid), 64'd0);
    chk("rr_stall_cnt", 64'(ex5_stall_cycles), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    dmem_if.dmem_req_ready = 1'b1;
    drive(OPC_STORE, 3'd1, 64'h700, 64'h10, 64'hBEEF, 1'b1, 1'b0);
    step();
    chk("post_req_valid", 64'(dmem_if.dmem_req_valid), 64'd1);
    chk("post_wstrb",     64'(dmem_if.dmem_req_wstrb), 64'h03);
    chk("post_wdata",     dmem_if.dmem_req_wdata, 64'hBEEF);
    drive(OPC_ALU, 3'd0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    step();
    chk("post_idle", 64'(dmem_if.dmem_req_valid), 64'd0);
    step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
